ising_anneal_ctrl: RTL
======================

Name: ising_anneal_ctrl

Overview:
- Sequencer that runs one Ising solve on the coupled-oscillator core matrix.
- Holds a shadow copy of the pairwise coupling weights and commits it to the matrix weight bus.
- Gates the matrix oscillator enable (`matrix_rstn`) through a reset/run window, then samples `outputs_hor`.
- Reports each spin's phase relative to spin 0 as the solution vector. Sits between a host/CSR interface and the core matrix.

Parameters:
- N, 3, number of spins (matrix dimension).
- NUM_WEIGHTS, 5, weight levels per coupling; W = $clog2(NUM_WEIGHTS) bits per weight.
- HOLD_CYCLES, 4, cycles `matrix_rstn` is held low after weight commit (≥1).
- RUN_CYCLES, 1024, settling cycles with oscillators enabled (≥1).
- SAMPLE_CYCLES, 64, cycles over which spin phases are majority-voted (≥1).

Ports:
- clk  in  1  system clock.
- rstn  in  1  asynchronous active-low reset.
- wr_en  in  1  shadow weight write strobe.
- wr_addr  in  $clog2(N*(N-1)/2)  pair index p = N*i - i*(i+1)/2 + j - i - 1, for i<j.
- wr_data  in  W  weight value.
- start  in  1  single-cycle request to begin a solve.
- abort  in  1  cancel the current solve.
- ack  in  1  host has consumed the result.
- weights  out  W*N*(N-1)/2  active weight bus to the matrix.
- matrix_rstn  out  1  oscillator enable to the matrix; low = held.
- outputs_hor  in  N  raw oscillator outputs from the matrix (asynchronous to clk).
- busy  out  1  high in LOAD/RUN/SAMPLE.
- done  out  1  result valid.
- result  out  N  spin vector; bit0 always 0.

Behaviour:
- Reset values:
  - State = IDLE; shadow and active weights = 0; `matrix_rstn` = 0.
  - `busy` = 0, `done` = 0, `result` = 0; all counters = 0.
- Shadow writes:
  - Accepted in any state when `wr_en` = 1; written on the next edge.
  - `wr_addr` ≥ N*(N-1)/2 is ignored.
  - Shadow writes never alter `weights` directly.
- States:
  - IDLE: on `start`, go to LOAD. `start` is ignored in every other state.
  - LOAD:
    - On entry, `weights` <= shadow; a write in the same cycle as entry is not included.
    - `matrix_rstn` stays 0 for HOLD_CYCLES cycles, then go to RUN.
  - RUN:
    - `matrix_rstn` = 1.
    - Counter runs 0..RUN_CYCLES-1; at terminal count go to SAMPLE.
  - SAMPLE:
    - `matrix_rstn` stays 1.
    - Every cycle, for k = 1..N-1, increment mis[k] if sync(outputs_hor[k]) != sync(outputs_hor[0]).
    - After SAMPLE_CYCLES cycles: `result[k]` = (2*mis[k] > SAMPLE_CYCLES), `result[0]` = 0. Go to DONE.
  - DONE:
    - `done` = 1, `matrix_rstn` = 0; `result` is stable.
    - On `ack`, go to IDLE: `done` drops on the next edge and `result` holds its value until the next SAMPLE completes.
- `busy` is 1 exactly in LOAD, RUN and SAMPLE.
- `abort` (any state except IDLE) on the next edge:
  - state = IDLE, `matrix_rstn` = 0, `done` = 0;
  - `result` and `weights` unchanged; counters cleared.
  - `abort` has priority over `start`, `ack` and terminal counts.
- Synchronizers:
  - `outputs_hor` passes through a 2-flop synchronizer per bit, always running.
  - Sampling uses the synchronized values only. The first 2 SAMPLE cycles may see RUN-phase data; this is accepted.
- Counter widths:
  - hold counter: $clog2(HOLD_CYCLES+1).
  - run counter: $clog2(RUN_CYCLES+1).
  - mis[k]: $clog2(SAMPLE_CYCLES+1); cannot overflow.
- Latency: `start` to `done` = 1 + HOLD_CYCLES + RUN_CYCLES + SAMPLE_CYCLES cycles.
- Asynchronous reset mid-solve returns all state to reset values immediately.

Decomposition:
- Shared package `ising_pkg`:
  - state enum (IDLE, LOAD, RUN, SAMPLE, DONE);
  - functions weight_w(NUM_WEIGHTS), num_pairs(N), pair_index(N,i,j).
- Sub-module `spin_phase_sampler`:
  - 2-flop synchronizer for N bits;
  - per-spin mismatch counters with clear/enable;
  - majority compare output.
- Controller FSM, weight shadow and counters stay in `ising_anneal_ctrl`.

Test Plan:
- Reset + idle: rstn low then high, no stimulus -> `weights`=0, `matrix_rstn`=0, `busy`=0, `done`=0, `result`=0.
- Weight commit (N=3, W=3): write p0=3, p1=5, p2=1, then start -> `weights` changes at LOAD entry to {3'd1,3'd5,3'd3}; a write of p0=7 during RUN leaves `weights` unchanged until the next start.
- Timing (HOLD=4, RUN=16, SAMPLE=8): start at cycle 0 -> `matrix_rstn` rises at cycle 5, `done` rises at cycle 29, `busy` high for cycles 1..28.
- Phase vote: `outputs_hor[0]` toggles each cycle, [1] equal to [0], [2] inverted from [0] -> `result` = 3'b100. Partial mismatch of 4 of 8 samples -> bit = 0; 5 of 8 -> bit = 1.
- Abort during RUN: counter at 10 -> next edge IDLE, `matrix_rstn`=0, `done`=0, previous `result` held; a subsequent start completes normally.
- Simultaneous events: `start` asserted in DONE with `ack` -> returns to IDLE, no new solve. `abort`+`start` in IDLE -> solve starts (abort inert in IDLE). `wr_addr`=3 with N=3 -> shadow unchanged.

Source files
------------

// File: rtl/ising_pkg.sv
// ising_pkg
// Shared types and elaboration-time helpers for the Ising anneal controller.
//   state_e      : controller state encoding
//   clog2_min1   : $clog2 clamped to at least one bit, so 1-entry fields keep a width
//   weight_w     : bits per coupling weight for a given number of weight levels
//   num_pairs    : number of unordered spin pairs (i<j) for an N-spin matrix
//   pair_index   : flat pair index p for spins i<j, matching the weight bus layout
package ising_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_RUN    = 3'd2,
    ST_SAMPLE = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  function automatic int clog2_min1(input int v);
    if (v <= 1) begin
      return 1;
    end else begin
      return $clog2(v);
    end
  endfunction

  function automatic int weight_w(input int num_weights);
    return clog2_min1(num_weights);
  endfunction

  function automatic int num_pairs(input int n);
    return (n * (n - 1)) / 2;
  endfunction

  function automatic int pair_index(input int n, input int i, input int j);
    return (n * i) - ((i * (i + 1)) / 2) + j - i - 1;
  endfunction

endpackage

// File: rtl/spin_phase_sampler.sv
// spin_phase_sampler
// Brings the matrix oscillator outputs into the clk domain and counts, for every
// spin k>0, how often its phase disagrees with spin 0 while sampling is enabled.
// Ports:
//   clk, rstn   : clock, asynchronous active-low reset
//   async_in    : raw oscillator outputs (asynchronous to clk)
//   clr         : zero all mismatch counters on the next edge (wins over en)
//   en          : count one sample on the next edge
//   vote_next   : majority decision using the counts as they will be after this
//                 edge, so the controller can latch it on the final sample edge.
//                 Bit 0 is the reference spin and is always 0.
module spin_phase_sampler
  import ising_pkg::*;
#(
  parameter int N             = 3,
  parameter int SAMPLE_CYCLES = 64
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [N-1:0] async_in,
  input  logic         clr,
  input  logic         en,
  output logic [N-1:0] vote_next
);

  localparam int MW = $clog2(SAMPLE_CYCLES + 1);
  localparam int VW = MW + 2;
  localparam logic [MW-1:0] ONE_M   = MW'(1);
  localparam logic [VW-1:0] SMP_LIM = VW'(SAMPLE_CYCLES);

  logic [N-1:0]         sync1_q, sync1_d;
  logic [N-1:0]         sync2_q, sync2_d;
  logic [N-1:0][MW-1:0] mis_q, mis_d;

  // Synchronizer next-state: free-running regardless of controller state.
  always_comb begin
    sync1_d = async_in;
    sync2_d = sync1_q;
  end

  // Mismatch counters and majority vote; 2*mis > SAMPLE_CYCLES is done as a
  // left shift into a wider word so no overflow is possible.
  always_comb begin
    mis_d     = mis_q;
    vote_next = '0;
    for (int k = 1; k < N; k++) begin
      if (clr) begin
        mis_d[k] = '0;
      end else if (en && (sync2_q[k] != sync2_q[0])) begin
        mis_d[k] = mis_q[k] + ONE_M;
      end else begin
        mis_d[k] = mis_q[k];
      end
      vote_next[k] = ({1'b0, mis_d[k], 1'b0} > SMP_LIM);
    end
  end

  // Sampler registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1_q <= '0;
      sync2_q <= '0;
      mis_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      mis_q   <= mis_d;
    end
  end

endmodule

// File: rtl/ising_anneal_ctrl.sv
// ising_anneal_ctrl
// Runs one Ising solve on the coupled-oscillator matrix: commits the shadow
// coupling weights, holds the oscillators in reset, lets them settle, then
// majority-votes each spin's phase against spin 0 into the result vector.
// Ports:
//   clk, rstn     : clock, asynchronous active-low reset
//   wr_en/addr/data : shadow weight write (out-of-range addresses ignored)
//   start         : begin a solve (honoured only in IDLE)
//   abort         : cancel an active solve; result and weights are kept
//   ack           : host consumed the result, leave DONE
//   weights       : active weight bus, pair p at bits [p*W +: W]
//   matrix_rstn   : oscillator enable, high only in RUN and SAMPLE
//   outputs_hor   : raw oscillator outputs (asynchronous)
//   busy, done    : solve in progress / result valid
//   result        : spin vector relative to spin 0 (bit 0 always 0)
module ising_anneal_ctrl
  import ising_pkg::*;
#(
  parameter int N             = 3,
  parameter int NUM_WEIGHTS   = 5,
  parameter int HOLD_CYCLES   = 4,
  parameter int RUN_CYCLES    = 1024,
  parameter int SAMPLE_CYCLES = 64,
  localparam int W            = weight_w(NUM_WEIGHTS),
  localparam int NP           = num_pairs(N),
  localparam int AW           = clog2_min1(NP)
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [W-1:0]    wr_data,
  input  logic            start,
  input  logic            abort,
  input  logic            ack,
  output logic [W*NP-1:0] weights,
  output logic            matrix_rstn,
  input  logic [N-1:0]    outputs_hor,
  output logic            busy,
  output logic            done,
  output logic [N-1:0]    result
);

  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int RW = $clog2(RUN_CYCLES + 1);
  localparam int SW = $clog2(SAMPLE_CYCLES + 1);

  localparam logic [HW-1:0]   HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [RW-1:0]   RUN_LAST  = RW'(RUN_CYCLES - 1);
  localparam logic [SW-1:0]   SMP_LAST  = SW'(SAMPLE_CYCLES - 1);
  localparam logic [HW-1:0]   HOLD_ONE  = HW'(1);
  localparam logic [RW-1:0]   RUN_ONE   = RW'(1);
  localparam logic [SW-1:0]   SMP_ONE   = SW'(1);
  localparam logic [AW:0]     NP_LIM    = (AW + 1)'(NP);

  state_e               state_q, state_d;
  logic [NP-1:0][W-1:0] shadow_q, shadow_d;
  logic [W*NP-1:0]      weights_q, weights_d;
  logic [HW-1:0]        hold_cnt_q, hold_cnt_d;
  logic [RW-1:0]        run_cnt_q, run_cnt_d;
  logic [SW-1:0]        smp_cnt_q, smp_cnt_d;
  logic [N-1:0]         result_q, result_d;
  logic                 matrix_rstn_q, matrix_rstn_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic                 abort_s;
  logic                 smp_clr_s;
  logic                 smp_en_s;
  logic [N-1:0]         vote_next_s;

  // abort is inert while idle, so a simultaneous start still launches a solve.
  assign abort_s   = abort && (state_q != ST_IDLE);
  assign smp_en_s  = (state_q == ST_SAMPLE);
  assign smp_clr_s = abort_s || (state_q != ST_SAMPLE);

  spin_phase_sampler #(
    .N             (N),
    .SAMPLE_CYCLES (SAMPLE_CYCLES)
  ) u_sampler (
    .clk       (clk),
    .rstn      (rstn),
    .async_in  (outputs_hor),
    .clr       (smp_clr_s),
    .en        (smp_en_s),
    .vote_next (vote_next_s)
  );

  // Shadow weight store: written in any state, never touches the active bus.
  always_comb begin
    shadow_d = shadow_q;
    if (wr_en && ({1'b0, wr_addr} < NP_LIM)) begin
      shadow_d[wr_addr] = wr_data;
    end else begin
      shadow_d = shadow_q;
    end
  end

  // Controller next state, counters, weight commit and result capture.
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    run_cnt_d  = run_cnt_q;
    smp_cnt_d  = smp_cnt_q;
    weights_d  = weights_q;
    result_d   = result_q;
    if (abort_s) begin
      state_d    = ST_IDLE;
      hold_cnt_d = '0;
      run_cnt_d  = '0;
      smp_cnt_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            // Commit uses the pre-edge shadow, so a same-cycle write misses it.
            state_d    = ST_LOAD;
            weights_d  = shadow_q;
            hold_cnt_d = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_LOAD: begin
          if (hold_cnt_q == HOLD_LAST) begin
            state_d    = ST_RUN;
            hold_cnt_d = '0;
            run_cnt_d  = '0;
          end else begin
            hold_cnt_d = hold_cnt_q + HOLD_ONE;
          end
        end
        ST_RUN: begin
          if (run_cnt_q == RUN_LAST) begin
            state_d   = ST_SAMPLE;
            run_cnt_d = '0;
            smp_cnt_d = '0;
          end else begin
            run_cnt_d = run_cnt_q + RUN_ONE;
          end
        end
        ST_SAMPLE: begin
          if (smp_cnt_q == SMP_LAST) begin
            // vote_next_s already includes the sample taken on this edge.
            state_d   = ST_DONE;
            smp_cnt_d = '0;
            result_d  = vote_next_s;
          end else begin
            smp_cnt_d = smp_cnt_q + SMP_ONE;
          end
        end
        ST_DONE: begin
          if (ack) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_DONE;
          end
        end
        default: begin
          state_d    = ST_IDLE;
          hold_cnt_d = '0;
          run_cnt_d  = '0;
          smp_cnt_d  = '0;
        end
      endcase
    end
  end

  // Status outputs decoded from the next state so they are registered yet
  // line up with the state they describe.
  always_comb begin
    matrix_rstn_d = 1'b0;
    busy_d        = 1'b0;
    done_d        = 1'b0;
    case (state_d)
      ST_IDLE: begin
        matrix_rstn_d = 1'b0;
      end
      ST_LOAD: begin
        busy_d = 1'b1;
      end
      ST_RUN: begin
        busy_d        = 1'b1;
        matrix_rstn_d = 1'b1;
      end
      ST_SAMPLE: begin
        busy_d        = 1'b1;
        matrix_rstn_d = 1'b1;
      end
      ST_DONE: begin
        done_d = 1'b1;
      end
      default: begin
        matrix_rstn_d = 1'b0;
      end
    endcase
  end

  // Controller registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= ST_IDLE;
      shadow_q      <= '0;
      weights_q     <= '0;
      hold_cnt_q    <= '0;
      run_cnt_q     <= '0;
      smp_cnt_q     <= '0;
      result_q      <= '0;
      matrix_rstn_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      shadow_q      <= shadow_d;
      weights_q     <= weights_d;
      hold_cnt_q    <= hold_cnt_d;
      run_cnt_q     <= run_cnt_d;
      smp_cnt_q     <= smp_cnt_d;
      result_q      <= result_d;
      matrix_rstn_q <= matrix_rstn_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign weights     = weights_q;
  assign matrix_rstn = matrix_rstn_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign result      = result_q;

endmodule
